// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite register bank with byte strobes, OKAY/SLVERR decode and independent read/write paths
module axi4_lite_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          NUM_REGS  = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [31:0]             araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [32*NUM_REGS-1:0]  regs_out
);
  localparam int          IW   = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN = 32'(4 * NUM_REGS);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t        w_state, w_next;
  r_state_t        r_state, r_next;
  logic [31:0]     regs [NUM_REGS];
  logic            aw_got, w_got, commit, w_in, r_in, unused_ok;
  logic [31:0]     awaddr_q, wdata_q, w_off, r_off;
  logic [3:0]      wstrb_q;
  logic [IW-1:0]   w_idx, r_idx;
  // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds
  assign w_off     = awaddr_q - BASE_ADDR;
  assign r_off     = araddr - BASE_ADDR;
  assign w_in      = w_off < SPAN;
  assign r_in      = r_off < SPAN;
  assign w_idx     = w_off[IW+1:2];
  assign r_idx     = r_off[IW+1:2];
  assign awready   = w_state == W_IDLE && !aw_got;
  assign wready    = w_state == W_IDLE && !w_got;
  assign bvalid    = w_state == W_RESP;
  assign arready   = r_state == R_IDLE;
  assign rvalid    = r_state == R_DATA;
  assign commit    = w_state == W_IDLE && aw_got && w_got;
  assign unused_ok = ^{awprot, arprot};
  always_comb begin
    w_next = commit ? W_RESP : (bvalid && bready) ? W_IDLE : w_state;
    r_next = (arvalid && arready) ? R_DATA : (rvalid && rready) ? R_IDLE : r_state;
  end
  always_comb begin
    regs_out = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_out[32*k +: 32] = regs[k];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp    <= 2'b00;
      rdata    <= '0;
      rresp    <= 2'b00;
    end else begin
      if (awvalid && awready) begin
        aw_got   <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_got   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bresp  <= w_in ? 2'b00 : 2'b10;
        if (w_in)
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) regs[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
      if (arvalid && arready) begin
        rdata <= r_in ? regs[r_idx] : '0;
        rresp <= r_in ? 2'b00 : 2'b10;
      end
    end
  end
endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder: a memory-mapped bank of 32-bit registers that sits on one slave port of the axi4_lite interconnect.
- Accepts independent write (AW/W/B) and read (AR/R) transactions.
- Applies byte strobes on writes.
- Returns OKAY for in-range accesses and SLVERR for out-of-range accesses.
- Exposes the register contents as a flat output for the system and the bench.

Parameters:
BASE_ADDR, 32'h0000_2000, base byte address of the register bank
NUM_REGS, 4, number of 32-bit registers (power of two, 2..16)

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
awaddr  input  32  write address
awprot  input  3  write protection (accepted, ignored)
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wstrb  input  4  byte strobes, bit i enables wdata[8i+7:8i]
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  32  read address
arprot  input  3  read protection (accepted, ignored)
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response
rvalid  output  1  read data valid
rready  input  1  read data ready
regs_out  output  32*NUM_REGS  register contents; reg k at [32k+31:32k]

Behaviour:
Reset (aresetn=0, asynchronous):
- All registers = 0.
- awready = wready = arready = 1.
- bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.

Address decode:
- Offset = addr - BASE_ADDR.
- In range when BASE_ADDR <= addr < BASE_ADDR + 4*NUM_REGS.
- Register index = offset[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
- Out of range: SLVERR, no register modified, rdata = 0.

Write FSM, states W_IDLE, W_RESP:
- W_IDLE: awready=1 until AW is captured; wready=1 until W is captured.
- AW and W may handshake in the same cycle or in either order; each is latched on its own handshake edge, then its ready drops.
- When both are latched, the next edge:
  - commits the write (bytes with wstrb=1 updated; wstrb=0 leaves that byte unchanged);
  - sets bvalid=1 and bresp;
  - enters W_RESP.
- Minimum latency: AW and W handshake at edge N -> write visible and bvalid=1 after edge N+1.
- W_RESP: awready=wready=0; bvalid and bresp held stable until bready=1.
- On the B handshake edge: bvalid=0, awready=wready=1, return to W_IDLE.

Read FSM, states R_IDLE, R_DATA:
- R_IDLE: arready=1.
- On the AR handshake edge: rdata and rresp are loaded from the current register values (pre-write value if a write commits on the same edge); rvalid=1; arready=0; enter R_DATA.
- Latency: rvalid high one cycle after the AR handshake.
- R_DATA: rdata, rresp and rvalid held until rready=1.
- On the R handshake edge: rvalid=0, arready=1, return to R_IDLE.

Concurrency and robustness:
- Read and write paths are fully independent; both may be active simultaneously.
- wstrb=0 with an in-range address: OKAY, no change.
- Reset mid-transaction: all state is abandoned immediately; the outstanding response is lost.
- No combinational path from any input to any output; all ready/valid signals are registered.

Test Plan:
- Reset, then check outputs: awready=wready=arready=1, bvalid=rvalid=0, regs_out=0.
- AW+W same cycle, awaddr=0x2000, wdata=128, wstrb=15 -> bvalid one cycle later, bresp=00, reg0=128; then read 0x2000 -> rvalid next cycle, rdata=128, rresp=00.
- W before AW by 2 cycles, addr 0x2004, wdata=0xAABBCCDD, wstrb=4'b1010 over prior 0 -> reg1=0xAA00CC00; hold bready=0 for 3 cycles -> bvalid and bresp stable, awready=0 throughout.
- Write to 0x2010 and read 0x1111 -> bresp=10 and rresp=10, rdata=0, regs_out unchanged.
- Read 0x2008 (reg2=5) with AR handshake on the same edge as a write commit of 9 to reg2 -> rdata=5; a subsequent read returns 9.
- aresetn pulsed low while bvalid=1 and rvalid=1 -> both drop asynchronously, registers=0, readies=1 after release.
